demux7_deserializer: RTL and testbench

//   Counterpart of the 7-input bit selector. It takes one serial bit per accepted

---
 rtl/demux7_deserializer.sv | 93 +++++++++
 tb/tb_demux7_deserializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux7_deserializer.sv
// Serial-to-parallel demux: steers one accepted bit per transfer into the next
// slot of an N_SLOTS-bit word, then holds the word under a valid/ack handshake.
`timescale 1ns/1ps
module demux7_deserializer #(
  parameter int N_SLOTS = 7,
  parameter int CNT_W   = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_bit,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [N_SLOTS-1:0] q,
  output logic               q_valid,
  input  logic               q_ack,
  output logic [CNT_W-1:0]   slot,
  output logic               fsm_state
);

  // Handshake: an input transfer happens on a rising edge where in_valid and
  // in_ready are both 1; the source must hold in_bit/in_valid until then. The
  // word is handed over on an edge where q_valid and q_ack are both 1.

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W:0]   NS_EXT = (CNT_W+1)'(N_SLOTS);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(N_SLOTS - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   slot_next;
  logic [CNT_W-1:0]   idx;
  logic [N_SLOTS-1:0] q_next;
  logic               xfer;

  assign xfer      = in_valid & in_ready;
  // An out-of-range slot value behaves as slot 0 on the next write.
  assign idx       = ({1'b0, slot} >= NS_EXT) ? '0 : slot;
  assign fsm_state = (state == FULL);

  always_comb begin
    state_next = state;
    slot_next  = slot;
    q_next     = q;
    if (flush) begin
      state_next = FILL;
      slot_next  = '0;
      q_next     = '0;
    end else begin
      case (state)
        FILL: begin
          if (xfer) begin
            for (int k = 0; k < N_SLOTS; k++) begin
              if (CNT_W'(k) == idx) q_next[k] = in_bit;
            end
            if (idx == LAST) begin
              slot_next  = '0;
              state_next = FULL;
            end else begin
              slot_next = idx + CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (q_ack) begin
            q_next     = '0;
            state_next = FILL;
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  // Handshake flags are registered copies of the next state so that in_ready
  // stays low through reset and rises on the first edge after release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= FILL;
      slot     <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      slot     <= slot_next;
      q        <= q_next;
      q_valid  <= (state_next == FULL);
      in_ready <= (state_next == FILL);
    end
  end

endmodule

// File: tb/tb_demux7_deserializer.sv
// Bench for demux7_deserializer: directed vector table, async-reset sequence,
// and a random valid/ack stress run checked through an expected-word queue.
`timescale 1ns/1ps
module tb_demux7_deserializer;

  localparam int W = 7;

  logic         clock;
  logic         resetn;
  logic         in_bit;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ack;
  logic [2:0]   slot;
  logic         fsm_state;

  demux7_deserializer #(.N_SLOTS(W), .CNT_W(3)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .q         (q),
    .q_valid   (q_valid),
    .q_ack     (q_ack),
    .slot      (slot),
    .fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic stress_done;

  typedef struct {
    logic         v;
    logic         b;
    logic         fl;
    logic         ack;
    logic [W-1:0] eq;
    logic         eqv;
    logic         erdy;
    logic [2:0]   eslot;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic b, input logic fl, input logic ack,
                              input logic [W-1:0] eq, input logic eqv, input logic erdy,
                              input logic [2:0] eslot);
    vec_t r;
    r.v = v; r.b = b; r.fl = fl; r.ack = ack;
    r.eq = eq; r.eqv = eqv; r.erdy = erdy; r.eslot = eslot;
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_table(input string tag);
    logic prev_eqv;
    prev_eqv = q_valid;
    foreach (tbl[i]) begin
      in_valid = tbl[i].v;
      in_bit   = tbl[i].b;
      flush    = tbl[i].fl;
      q_ack    = tbl[i].ack;
      if (tbl[i].eqv && !prev_eqv) exp_q.push_back(tbl[i].eq);
      prev_eqv = tbl[i].eqv;
      step();
      check({tag, "_q"},        i, 8'(q),        8'(tbl[i].eq));
      check({tag, "_q_valid"},  i, 8'(q_valid),  8'(tbl[i].eqv));
      check({tag, "_in_ready"}, i, 8'(in_ready), 8'(tbl[i].erdy));
      check({tag, "_slot"},     i, 8'(slot),     8'(tbl[i].eslot));
    end
    tbl.delete();
    in_valid = 1'b0;
    in_bit   = 1'b0;
    flush    = 1'b0;
    q_ack    = 1'b0;
  endtask

  logic [W-1:0] m_word;
  int           m_cnt;

  task automatic send_bit(input logic b);
    logic acc;
    int   guard;
    guard    = 0;
    in_valid = 1'b1;
    in_bit   = b;
    acc      = 1'b0;
    while (!acc) begin
      acc = in_ready;
      step();
      guard++;
      if (!acc && guard > 200) begin
        checks++;
        failures++;
        $display("FAIL stress_accept_timeout: got no in_ready after %0d cycles, expected acceptance", guard);
        break;
      end
    end
    in_valid = 1'b0;
    m_word[m_cnt] = b;
    m_cnt++;
    if (m_cnt == W) begin
      exp_q.push_back(m_word);
      m_cnt  = 0;
      m_word = '0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic monitor();
    logic         prev_qv;
    logic [W-1:0] e;
    prev_qv = 1'b0;
    forever begin
      @(negedge clock);
      if (q_valid && !prev_qv) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_word: got q=%0h with q_valid, expected no word", q);
        end else begin
          e = exp_q.pop_front();
          check("sb_word", 0, 8'(q), 8'(e));
        end
      end
      prev_qv = q_valid;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    resetn      = 1'b0;
    in_bit      = 1'b1;
    in_valid    = 1'b1;
    flush       = 1'b0;
    q_ack       = 1'b0;
    stress_done = 1'b0;
    m_word      = '0;
    m_cnt       = 0;
    fork monitor(); join_none

    // Reset held for 3 cycles with in_valid high.
    repeat (3) step();
    check("rst_q",        0, 8'(q),        8'h00);
    check("rst_q_valid",  0, 8'(q_valid),  8'h00);
    check("rst_slot",     0, 8'(slot),     8'h00);
    check("rst_in_ready", 0, 8'(in_ready), 8'h00);
    in_valid = 1'b0;
    #2 resetn = 1'b1;
    step();
    check("rel_in_ready", 0, 8'(in_ready), 8'h01);
    check("rel_q_valid",  0, 8'(q_valid),  8'h00);

    // Fill 1,0,1,1,0,0,1 then backpressure, ack, flush, clean word, collision.
    add(1,1,0,0, 7'b0000001,0,1,1);
    add(1,0,0,0, 7'b0000001,0,1,2);
    add(1,1,0,0, 7'b0000101,0,1,3);
    add(1,1,0,0, 7'b0001101,0,1,4);
    add(1,0,0,0, 7'b0001101,0,1,5);
    add(1,0,0,0, 7'b0001101,0,1,6);
    add(1,1,0,0, 7'b1001101,1,0,0);
    for (int i = 0; i < 5; i++) add(1,1,0,0, 7'b1001101,1,0,0);
    add(1,1,0,1, 7'b0000000,0,1,0);
    add(1,1,0,0, 7'b0000001,0,1,1);
    add(1,0,0,0, 7'b0000001,0,1,2);
    add(1,1,0,0, 7'b0000101,0,1,3);
    add(1,1,0,0, 7'b0001101,0,1,4);
    add(1,1,1,0, 7'b0000000,0,1,0);
    add(1,0,0,0, 7'b0000000,0,1,1);
    add(1,1,0,0, 7'b0000010,0,1,2);
    add(1,1,0,0, 7'b0000110,0,1,3);
    add(1,0,0,0, 7'b0000110,0,1,4);
    add(1,1,0,0, 7'b0010110,0,1,5);
    add(1,0,0,0, 7'b0010110,0,1,6);
    add(1,0,0,0, 7'b0010110,1,0,0);
    add(1,1,0,1, 7'b0000000,0,1,0);
    add(1,1,0,0, 7'b0000001,0,1,1);
    add(0,0,0,1, 7'b0000001,0,1,1);
    add(1,0,0,0, 7'b0000001,0,1,2);
    add(1,1,0,0, 7'b0000101,0,1,3);
    run_table("dir");

    // Async reset between edges, three bits into a word.
    #3 resetn = 1'b0;
    #1;
    check("arst_q",        0, 8'(q),        8'h00);
    check("arst_slot",     0, 8'(slot),     8'h00);
    check("arst_q_valid",  0, 8'(q_valid),  8'h00);
    check("arst_in_ready", 0, 8'(in_ready), 8'h00);
    step();
    #2 resetn = 1'b1;
    step();
    check("arst_rel_in_ready", 0, 8'(in_ready), 8'h01);
    check("arst_rel_q_valid",  0, 8'(q_valid),  8'h00);

    // All-ones word, then flush beating ack and a pending bit while FULL.
    for (int k = 0; k < W; k++)
      add(1,1,0,0, 7'((1 << (k+1)) - 1), logic'(k == W-1), logic'(k != W-1), 3'((k == W-1) ? 0 : k+1));
    add(1,1,1,1, 7'b0000000,0,1,0);
    add(1,1,0,0, 7'b0000001,0,1,1);
    add(0,0,1,0, 7'b0000000,0,1,0);
    run_table("flush");

    // Random valid/ack stress over 1000 words.
    fork
      begin
        for (int w = 0; w < 1000; w++) begin
          for (int b = 0; b < W; b++) begin
            repeat ($urandom_range(0, 2)) step();
            send_bit(logic'($urandom_range(0, 1)));
          end
        end
        for (int g = 0; g < 100 && exp_q.size() != 0; g++) step();
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          q_ack = logic'($urandom_range(0, 3) != 0);
          step();
        end
        q_ack = 1'b0;
      end
    join
    repeat (2) step();
    check("sb_drain", 0, 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
